// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Two-port arbiter and sequencer in front of a single-port synchronous RAM.
// Port 0 (instruction fetch) and port 1 (data access) each issue independent
// read/write requests; one transaction is granted at a time and run through
// a small state machine that drives the RAM controls and the shared data bus.
//
// Build option:
//   RAM_ARB_FIXED_PRIO_EN  defined   -> fixed priority, port 0 wins every tie
//                          undefined -> round-robin between the two ports
//
// Ports:
//   clk                 rising-edge clock shared with the RAM
//   rst_n               asynchronous active-low reset
//   req0/req1           request, held high until the matching ack
//   we0/we1             1 = write, 0 = read (stable while req is high)
//   addr0/addr1         target address (stable while req is high)
//   wdata0/wdata1       write data (stable while req is high)
//   ack0/ack1           one-cycle completion pulse
//   rdata0/rdata1       read result, valid in the ack cycle, held until the
//                       port's next read
//   busy                high whenever the sequencer is not idle
//   ram_cs/ram_we/ram_oe RAM controls
//   ram_addr            RAM address (0 whenever the RAM is not selected)
//   ram_data            bidirectional RAM data bus, driven only while writing

module ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_CAP,
    WR,
    ACK
  } state_t;

  state_t                state;
  logic                  owner;     // port that currently holds the RAM
  logic                  we_l;
  logic [ADDR_WIDTH-1:0] addr_l;
  logic [DATA_WIDTH-1:0] wdata_l;

  logic                  gnt_valid;
  logic                  gnt_port;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                  rr;        // last granted port; the other one wins a tie
`endif

  // Grant decision, only consumed in IDLE
  always_comb begin
    gnt_valid = req0 | req1;
`ifdef RAM_ARB_FIXED_PRIO_EN
    gnt_port  = ~req0;
`else
    if (req0 && req1) begin
      gnt_port = ~rr;
    end else begin
      gnt_port = req1;
    end
`endif
  end

  // Control state: sequencer, owner, pointer and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      we_l   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      rr     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= gnt_port;
            we_l  <= gnt_port ? we1 : we0;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr    <= gnt_port;
`endif
            if (gnt_port ? we1 : we0) begin
              state <= WR;
            end else begin
              state <= RD_ADDR;
            end
          end
        end
        RD_ADDR: state <= RD_CAP;
        RD_CAP: begin
          // RAM has been driving the registered word for this whole cycle
          if (owner) begin
            rdata1 <= ram_data;
          end else begin
            rdata0 <= ram_data;
          end
          state <= ACK;
        end
        WR:      state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request payload, latched at grant; never observed outside an active state
  always_ff @(posedge clk) begin
    if (state == IDLE && gnt_valid) begin
      addr_l  <= gnt_port ? addr1 : addr0;
      wdata_l <= gnt_port ? wdata1 : wdata0;
    end
  end

  // Outputs decoded from state/owner only, so reset drops them immediately
  assign busy     = (state != IDLE);
  assign ram_cs   = (state == RD_ADDR) || (state == RD_CAP) || (state == WR);
  assign ram_oe   = (state == RD_ADDR) || (state == RD_CAP);
  assign ram_we   = (state == WR) && we_l;
  assign ram_addr = ram_cs ? addr_l : '0;
  assign ram_data = (state == WR) ? wdata_l : {DATA_WIDTH{1'bz}};
  assign ack0     = (state == ACK) && !owner;
  assign ack1     = (state == ACK) && owner;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural synchronous RAM sits on the ram_* bus,
// directed transactions are issued per port, and each expected acknowledge is
// queued when issued and matched by an independent ack monitor.

module tb_ram_arbiter;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       req0   = 1'b0;
  logic       req1   = 1'b0;
  logic       we0    = 1'b0;
  logic       we1    = 1'b0;
  logic [3:0] addr0  = '0;
  logic [3:0] addr1  = '0;
  logic [7:0] wdata0 = '0;
  logic [7:0] wdata1 = '0;

  wire        ack0, ack1, busy, ram_cs, ram_we, ram_oe;
  wire  [7:0] rdata0, rdata1;
  wire  [3:0] ram_addr;
  wire  [7:0] ram_data;

  ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM model; contents start as 0xA0 + address
  logic [7:0] mem [16];
  logic [7:0] ram_q = '0;
  bit         mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
      mem_ready <= 1'b1;
    end else if (ram_cs && ram_we) begin
      mem[ram_addr] <= ram_data;
    end
    if (ram_cs && ram_oe && !ram_we) ram_q <= mem[ram_addr];
  end

  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 8'bz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issue_cyc [2];
  int we_cycles = 0;
  int viol = 0;
  logic [7:0] last_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus protocol watch: no read/write overlap, busy exactly when not idle
  always @(negedge clk) begin
    if (ram_we) begin
      we_cycles++;
      last_wdata = ram_data;
    end
    if (ram_we && ram_oe) viol++;
    if (busy != (ram_cs | ack0 | ack1)) viol++;
  end

  // Scoreboard
  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t q[$];
  exp_t e;

  function automatic void expect_txn(input int port, input bit rd, input logic [7:0] d, input int lat);
    exp_t x;
    x.port = port; x.rd = rd; x.data = d; x.lat = lat;
    q.push_back(x);
  endfunction

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      chk("ack_exclusive", {31'd0, ack0 & ack1}, 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b at cycle %0d, none expected", ack0, ack1, cyc);
      end else begin
        e = q.pop_front();
        chk("ack_port", {31'd0, ack1}, e.port);
        if (e.rd) chk("rdata", (e.port != 0) ? rdata1 : rdata0, e.data);
        if (e.lat >= 0) chk("latency", cyc - issue_cyc[e.port], e.lat);
      end
    end
  end

  // Issue one transaction on a port and wait (bounded) for its ack
  task automatic do_txn(input int port, input bit w, input logic [3:0] a, input logic [7:0] d);
    bit got = 1'b0;
    if (port == 0) begin
      we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1;
    end else begin
      we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1;
    end
    issue_cyc[port] = cyc;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (port != 0) ? ack1 : ack0;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL txn_timeout: port %0d got no ack, expected one within 100 cycles", port);
    end
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected $finish before 200000");
    $fatal(1, "watchdog");
  end

  int n_we;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cs", {31'd0, ram_cs}, 0);
    chk("rst_we", {31'd0, ram_we}, 0);
    chk("rst_oe", {31'd0, ram_oe}, 0);
    chk("rst_addr", {28'd0, ram_addr}, 0);
    chk("rst_rdata0", {24'd0, rdata0}, 0);
    chk("rst_rdata1", {24'd0, rdata1}, 0);
    rst_n = 1'b1;

    // Tie right after reset: port 0 first, reads the initial contents
    expect_txn(0, 1, 8'hA1, -1);
    expect_txn(1, 0, 8'h00, -1);
    fork
      do_txn(0, 1'b0, 4'd1, 8'h00);
      do_txn(1, 1'b1, 4'd2, 8'h77);
    join
    expect_txn(0, 1, 8'h77, -1);
    do_txn(0, 1'b0, 4'd2, 8'h00);

    // Single read with latency
    expect_txn(1, 0, 8'h00, -1);
    do_txn(1, 1'b1, 4'd3, 8'h5A);
    @(negedge clk);
    expect_txn(0, 1, 8'h5A, 3);
    do_txn(0, 1'b0, 4'd3, 8'h00);

    // Single write with latency and one-cycle write strobe
    @(negedge clk);
    n_we = we_cycles;
    expect_txn(0, 0, 8'h00, 2);
    do_txn(0, 1'b1, 4'hF, 8'hC3);
    chk("wr_we_cycles", we_cycles - n_we, 1);
    chk("wr_bus_data", {24'd0, last_wdata}, 32'hC3);
    @(negedge clk);
    expect_txn(1, 1, 8'hC3, 3);
    do_txn(1, 1'b0, 4'hF, 8'h00);

    // Sustained contention, 8 transactions per port
    @(negedge clk);
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 8; i++) expect_txn(0, 1, 8'hA4, -1);
    for (int i = 0; i < 8; i++) expect_txn(1, 0, 8'h00, -1);
`else
    for (int i = 0; i < 8; i++) begin
      expect_txn(0, 1, 8'hA4, -1);
      expect_txn(1, 0, 8'h00, -1);
    end
`endif
    fork
      begin
        for (int i = 0; i < 8; i++) do_txn(0, 1'b0, 4'd4, 8'h00);
      end
      begin
        for (int j = 0; j < 8; j++) do_txn(1, 1'b1, 4'(8 + j), 8'(8'h40 + j));
      end
    join
    expect_txn(0, 1, 8'h44, -1);
    do_txn(0, 1'b0, 4'd12, 8'h00);

    // Reset in the middle of a write
    expect_txn(0, 0, 8'h00, -1);
    do_txn(0, 1'b1, 4'd5, 8'h11);
    @(negedge clk);
    we1 = 1'b1; addr1 = 4'd5; wdata1 = 8'hEE; req1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rstwr_we_active", {31'd0, ram_we}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwr_cs_drop", {31'd0, ram_cs}, 0);
    chk("rstwr_we_drop", {31'd0, ram_we}, 0);
    chk("rstwr_busy_drop", {31'd0, busy}, 0);
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstwr_rdata0", {24'd0, rdata0}, 0);
    chk("rstwr_rdata1", {24'd0, rdata1}, 0);
    rst_n = 1'b1;
    expect_txn(0, 1, 8'h11, 3);
    do_txn(0, 1'b0, 4'd5, 8'h00);

    // Read data held across a write on the same port
    @(negedge clk);
    expect_txn(0, 0, 8'h00, 2);
    do_txn(0, 1'b1, 4'd6, 8'h22);
    chk("iso_rdata0", {24'd0, rdata0}, 32'h11);
    chk("iso_rdata1", {24'd0, rdata1}, 0);
    @(negedge clk);
    expect_txn(1, 1, 8'h22, 3);
    do_txn(1, 1'b0, 4'd6, 8'h00);
    chk("iso_rdata0_after", {24'd0, rdata0}, 32'h11);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    chk("bus_protocol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the single-port synchronous tweakram. It accepts independent read/write requests from two masters (port 0: instruction fetch, port 1: data access) and grants one at a time, round-robin. It drives the RAM's cs/we/oe/address and the shared bidirectional data bus, and returns read data with a one-cycle acknowledge. It sits between the CPU core's memory ports and the RAM instance.

## Interface
- DATA_WIDTH, 8, RAM word width.
- ADDR_WIDTH, 4, RAM address width.
- clk  in  1  rising-edge clock shared with the RAM.
- rst_n  in  1  reset; asynchronous, active-low.
- req0, req1  in  1  transaction request, held high until ack.
- we0, we1  in  1  1 = write, 0 = read; stable while req high.
- addr0, addr1  in  ADDR_WIDTH  target address; stable while req high.
- wdata0, wdata1  in  DATA_WIDTH  write data; stable while req high.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata0, rdata1  out  DATA_WIDTH  read result, valid in the ack cycle, held until the port's next read.
- busy  out  1  high in any state other than IDLE.
- ram_cs, ram_we, ram_oe  out  1  RAM controls.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only in WR, hi-Z otherwise.

## Operation
- States: IDLE, RD_ADDR, RD_CAP, WR, ACK. All outputs are registered or decoded directly from the state and owner registers, with no combinational path from req inputs.
- IDLE: sample req0/req1 at the clock edge.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the port not granted last (rr pointer).
  - On grant, latch owner, we, addr and wdata, and update the pointer to the owner.
  - Next state is WR if we = 1, else RD_ADDR.
- RD_ADDR: ram_cs=1, ram_oe=1, ram_we=0, ram_addr=latched addr. The RAM registers the word at the edge ending this cycle. Next state is RD_CAP.
- RD_CAP: keep the same controls. The RAM drives ram_data. Capture ram_data into the owner's rdata at the cycle-ending edge. Next state is ACK.
- WR: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=addr, ram_data=wdata. The RAM writes at the cycle-ending edge. Next state is ACK.
- ACK: all ram_* controls are 0, ram_data is hi-Z, and the owner's ack is 1. Next state is IDLE. No grant is made in ACK.
- A requester drops req at the edge ending its ack cycle. If req is still high at the following IDLE sample, that is a new transaction.
- The non-owner's req is ignored until the next IDLE. Its inputs must stay stable while it waits.
- rdata of a port changes only on that port's reads. Writes leave both rdata registers untouched.

## Timing
- Reset values:
  - state = IDLE
  - ram_cs = ram_we = ram_oe = 0, ram_addr = 0, ram_data hi-Z
  - ack0 = ack1 = 0, rdata0 = rdata1 = 0, busy = 0
  - rr pointer = port 1, so port 0 wins the first tie.
- Read, with req sampled at edge E0:
  - RD_ADDR in cycle 1, RD_CAP in cycle 2, ack in cycle 3.
  - Latency is 3 cycles from sample to ack.
  - Throughput is one read per 4 cycles (back-to-back re-grant in IDLE).
- Write, with req sampled at E0: WR in cycle 1, ack in cycle 2. Latency is 2 cycles; throughput is one write per 3 cycles.
- Both requesters held high: grants strictly alternate 0,1,0,1.
- The bus is never driven by both RAM and arbiter. ram_we and ram_oe are never both 1, and ram_data is driven only while ram_we=1.
- Reset asserted mid-transaction:
  - All ram_* controls drop immediately (asynchronous).
  - The transaction is aborted with no ack.
  - A write is lost unless its edge completed before reset.
  - After reset release, the first edge samples in IDLE.

## Configuration
- RAM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, port 0 always wins a tie. The rr pointer is not implemented. Port 1 can starve if port 0 re-requests continuously.
  - Undefined (default): round-robin as described above.

## Test plan
- Single read: port 1 writes 0x5A to addr 3. Port 0 then reads addr 3. Required: ack0 exactly 3 cycles after the req sample, rdata0=0x5A, ack1 never pulses during the read.
- Single write: port 0 writes 0xC3 to addr 0xF. Required: ram_we high for exactly one cycle with ram_data=0xC3, then ack0 two cycles after the sample. A subsequent read of addr 0xF returns 0xC3.
- Tie: both ports request in the same cycle after reset (port 0 reads addr 1, port 1 writes 0x77 to addr 2). Required: port 0 is served first, port 1 next.
  - Round-robin: port 0's read returns the prior contents of addr 1.
  - With RAM_ARB_FIXED_PRIO_EN and port 0 holding req continuously, port 1 is never granted.
- Sustained contention: both ports hold req for 8 transactions each. Required: alternating acks 0,1,0,1,…, no double-driven bus (no X on ram_data), and busy low only in IDLE cycles.
- Reset mid-write: assert rst_n=0 during WR before the edge (port 1 writing 0xEE to addr 5, addr 5 previously 0x11). Required: controls drop immediately, no ack, addr 5 still reads 0x11 after reset.
- Read-after-write isolation: port 0 reads 0x11 from addr 5, then port 0 writes 0x22 to addr 6. Required: rdata0 holds 0x11 through the write and its ack.
